compare_gen: RTL and testbench



---
 rtl/compare_gen_pkg.sv | 46 ++++
 rtl/compare_01.sv | 11 +
 rtl/lfsr16_step.sv | 11 +
 rtl/compare_gen.sv | 101 ++++++++++
 tb/tb_compare_gen.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/compare_gen_pkg.sv
// Shared constants and the triple-shaping rule used by the compare_01 stimulus generator.
package compare_gen_pkg;

  localparam int          LFSR_W       = 16;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  localparam logic [1:0] POS_A = 2'd0;
  localparam logic [1:0] POS_B = 2'd1;
  localparam logic [1:0] POS_C = 2'd2;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
  } triple_t;

  // L[0] picks between the two MSB counts allowed for the requested result,
  // L[3:2] picks which operand is the odd one out.
  function automatic triple_t mk_triple(input logic [LFSR_W-1:0] l, input logic rc);
    triple_t    t;
    logic [1:0] nh;
    logic [1:0] p;
    logic [2:0] sel;
    logic [2:0] msb;
    if (rc) nh = l[0] ? 2'd3 : 2'd2;
    else    nh = l[0] ? 2'd1 : 2'd0;
    p = (l[3:2] == 2'd3) ? POS_A : l[3:2];
    case (p)
      POS_A:   sel = 3'b001;
      POS_B:   sel = 3'b010;
      default: sel = 3'b100;
    endcase
    case (nh)
      2'd0:    msb = 3'b000;
      2'd1:    msb = sel;
      2'd2:    msb = ~sel;
      default: msb = 3'b111;
    endcase
    t.a = {msb[0], l[6:4]};
    t.b = {msb[1], l[9:7]};
    t.c = {msb[2], l[12:10]};
    return t;
  endfunction

endpackage

// File: rtl/compare_01.sv
// 3-input majority comparator: result is 1 when at least two operands are >= 8.
module compare_01 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] c_i,
  output logic       rc_o
);

  assign rc_o = (a_i[3] & b_i[3]) | (a_i[3] & c_i[3]) | (b_i[3] & c_i[3]);

endmodule

// File: rtl/lfsr16_step.sv
// One step of the right-shifting Galois LFSR; purely combinational.
module lfsr16_step
  import compare_gen_pkg::*;
(
  input  logic [LFSR_W-1:0] lfsr_i,
  output logic [LFSR_W-1:0] lfsr_o
);

  assign lfsr_o = (lfsr_i >> 1) ^ (lfsr_i[0] ? LFSR_TAPS : '0);

endmodule

// File: rtl/compare_gen.sv
// Request-driven triple generator for compare_01 with a single-entry output register
// and a built-in checker that flags any triple not matching its requested result.
module compare_gen
  import compare_gen_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_a,
  output logic [3:0]  out_b,
  output logic [3:0]  out_c,
  output logic        out_rc,
  output logic [15:0] gen_count,
  output logic        chk_err
);

  // An all-zero seed would lock the LFSR, so it is nudged to 1.
  localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? 16'h0001 : SEED;

  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_next;
  logic              out_valid_q, out_valid_d;
  triple_t           triple_q, triple_d;
  logic              out_rc_q, out_rc_d;
  logic [15:0]       gen_count_q, gen_count_d;
  logic              chk_err_q, chk_err_d;
  logic              accept;
  logic              handshake;
  logic              cmp_rc;

  lfsr16_step u_step (
    .lfsr_i (lfsr_q),
    .lfsr_o (lfsr_next)
  );

  compare_01 u_check (
    .a_i  (triple_q.a),
    .b_i  (triple_q.b),
    .c_i  (triple_q.c),
    .rc_o (cmp_rc)
  );

  assign req_ready = !out_valid_q || out_ready;
  assign accept    = req_valid && req_ready;
  assign handshake = out_valid_q && out_ready;

  always_comb begin
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    triple_d    = triple_q;
    out_rc_d    = out_rc_q;
    gen_count_d = gen_count_q;
    chk_err_d   = chk_err_q;

    // A new accept overwrites a draining entry, so valid only drops on a bare drain.
    if (accept) begin
      lfsr_d      = lfsr_next;
      out_valid_d = 1'b1;
      triple_d    = mk_triple(lfsr_q, req_rc);
      out_rc_d    = req_rc;
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end

    if (handshake && (gen_count_q != 16'hFFFF)) gen_count_d = gen_count_q + 16'd1;

    if (out_valid_q && (cmp_rc != out_rc_q)) chk_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= SEED_SAFE;
      out_valid_q <= 1'b0;
      triple_q    <= '0;
      out_rc_q    <= 1'b0;
      gen_count_q <= '0;
      chk_err_q   <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      triple_q    <= triple_d;
      out_rc_q    <= out_rc_d;
      gen_count_q <= gen_count_d;
      chk_err_q   <= chk_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = triple_q.a;
  assign out_b     = triple_q.b;
  assign out_c     = triple_q.c;
  assign out_rc    = out_rc_q;
  assign gen_count = gen_count_q;
  assign chk_err   = chk_err_q;

endmodule

// File: tb/tb_compare_gen.sv
// Randomized self-checking bench for compare_gen against a behavioural model and triple scoreboard.
module tb_compare_gen;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_rc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_a;
  logic [3:0]  out_b;
  logic [3:0]  out_c;
  logic        out_rc;
  logic [15:0] gen_count;
  logic        chk_err;

  int checks;
  int failures;

  int          mLfsr;
  bit          mValid;
  int          mCount;
  int          hsCount;
  logic [12:0] sb[$];

  compare_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rc    (req_rc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_rc    (out_rc),
    .gen_count (gen_count),
    .chk_err   (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Triple from the generation rule: pick MSB count from rc and L[0], odd position from L[3:2].
  function automatic logic [12:0] refTriple(input int l, input bit rc);
    int nh;
    int p;
    int v[3];
    bit hi;
    logic [3:0] a, b, c;
    nh = rc ? (((l & 1) != 0) ? 3 : 2) : (((l & 1) != 0) ? 1 : 0);
    p  = (l >> 2) & 3;
    if (p == 3) p = 0;
    v[0] = (l >> 4) & 7;
    v[1] = (l >> 7) & 7;
    v[2] = (l >> 10) & 7;
    for (int i = 0; i < 3; i++) begin
      hi = (nh == 3) || (nh == 2 && i != p) || (nh == 1 && i == p);
      if (hi) v[i] += 8;
    end
    a = 4'(v[0]);
    b = 4'(v[1]);
    c = 4'(v[2]);
    return {a, b, c, rc};
  endfunction

  function automatic int refLfsr(input int l);
    return (l >> 1) ^ (((l & 1) != 0) ? 32'hB400 : 0);
  endfunction

  task automatic resetModel();
    mLfsr  = 32'hACE1;
    mValid = 1'b0;
    mCount = 0;
    sb.delete();
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input bit v, input bit rc, input bit rdy);
    bit acc;
    bit hs;
    req_valid = v;
    req_rc    = rc;
    out_ready = rdy;
    @(negedge clk);
    acc = v && (!mValid || rdy);
    hs  = mValid && rdy;
    checkOutput("req_ready", 32'(req_ready), 32'(!mValid || rdy));
    checkOutput("out_valid", 32'(out_valid), 32'(mValid));
    if (mValid) begin
      if (sb.size() == 0) checkOutput("sb_empty", 32'(sb.size()), 32'd1);
      else checkOutput("triple", 32'({out_a, out_b, out_c, out_rc}), 32'(sb[0]));
    end
    checkOutput("gen_count", 32'(gen_count), 32'(mCount));
    checkOutput("chk_err", 32'(chk_err), 32'd0);
    @(posedge clk);
    if (hs) begin
      if (sb.size() != 0) void'(sb.pop_front());
      if (mCount < 32'hFFFF) mCount++;
      hsCount++;
    end
    if (acc) begin
      sb.push_back(refTriple(mLfsr, rc));
      mLfsr = refLfsr(mLfsr);
    end
    mValid = acc ? 1'b1 : (hs ? 1'b0 : mValid);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    hsCount   = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_rc    = 1'b0;
    out_ready = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("rst_a", 32'(out_a), 32'd0);
    checkOutput("rst_b", 32'(out_b), 32'd0);
    checkOutput("rst_c", 32'(out_c), 32'd0);
    checkOutput("rst_rc", 32'(out_rc), 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("dir1", 32'({out_a, out_b, out_c, out_rc}), 32'({4'hE, 4'h9, 4'hB, 1'b1}));
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("dir2", 32'({out_a, out_b, out_c, out_rc}), 32'({4'h7, 4'h4, 4'h0, 1'b0}));
    checkOutput("dir2_count", 32'(gen_count), 32'd1);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("b2b_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 10000; i++)
      applyStimulus(($urandom % 4) != 0, 1'($urandom), ($urandom % 3) != 0);
    checkOutput("hs_count", 32'(gen_count), 32'(hsCount));
    checkOutput("sb_depth", 32'(sb.size()), 32'(mValid));

    // Mid-stream asynchronous reset with a pending triple
    applyStimulus(1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_a", 32'(out_a), 32'd0);
    checkOutput("rst_mid_count", 32'(gen_count), 32'd0);
    req_valid = 1'b0;
    resetModel();
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("rst_first", 32'({out_a, out_b, out_c, out_rc}), 32'({4'hE, 4'h9, 4'hB, 1'b1}));

    // Saturation of the handshake counter
    applyStimulus(1'b0, 1'b0, 1'b0);
    force dut.gen_count_q = 16'hFFFE;
    #1;
    release dut.gen_count_q;
    mCount = 32'hFFFE;
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("sat_reach", 32'(gen_count), 32'hFFFF);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("sat_hold", 32'(gen_count), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
